// File: rtl/l0_seq_ctrl_if.sv
// Command, SRAM and L0 signal bundle for the L0 job sequencer.
// master: decoder/L0 side; slave: the sequencer itself.
interface l0_seq_ctrl_if #(
  parameter int addr_w = 11,
  parameter int len_w  = 7
);
  logic              start;
  logic [addr_w-1:0] base_addr;
  logic [len_w-1:0]  len;
  logic              l0_ready;
  logic              sram_cen;
  logic              sram_wen;
  logic [addr_w-1:0] sram_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, len, l0_ready,
    input  sram_cen, sram_wen, sram_addr,
    input  l0_wr, l0_rd, busy, done, err
  );

  modport slave (
    input  start, base_addr, len, l0_ready,
    output sram_cen, sram_wen, sram_addr,
    output l0_wr, l0_rd, busy, done, err
  );
endinterface

// File: rtl/l0_seq_ctrl.sv
// L0 job sequencer: streams len vectors SRAM->L0, then holds
// l0_rd for the full row-staggered drain wave.
module l0_seq_ctrl #(
  parameter int row    = 8,
  parameter int depth  = 64,
  parameter int addr_w = 11,
  parameter int len_w  = 7
) (
  input logic clk,
  input logic reset,
  l0_seq_ctrl_if.slave bus
);

  localparam int cw = len_w + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, DRAIN, DONE
  } state_t;

  state_t state, nxt;

  logic [cw-1:0]     len_q, len_d;
  logic [cw-1:0]     cnt_q, cnt_d;
  logic [cw-1:0]     len_in, drain_n;
  logic [addr_w-1:0] ptr_q, ptr_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic              cen_q, cen_d;
  logic              wr_q;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign len_in  = {1'b0, bus.len};
  assign drain_n = len_q + cw'(row - 1);

  always_comb begin
    nxt    = state;
    len_d  = len_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    cen_d  = 1'b1;
    rd_d   = 1'b0;
    busy_d = 1'b0;
    err_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (len_in == '0) begin
            nxt    = DONE;
            busy_d = 1'b1;
          end else if (len_in > cw'(depth)) begin
            err_d = 1'b1;
          end else begin
            nxt   = LOAD;
            len_d = len_in;
            cnt_d = '0;
            ptr_d = bus.base_addr;
            if (bus.l0_ready) begin
              cen_d  = 1'b0;
              addr_d = bus.base_addr;
              ptr_d  = bus.base_addr + 1'b1;
              cnt_d  = cw'(1);
            end
          end
        end
      end
      LOAD: begin
        if (cnt_q == len_q) begin
          nxt = FLUSH;
        end else if (bus.l0_ready) begin
          cen_d  = 1'b0;
          addr_d = ptr_q;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        nxt   = DRAIN;
        rd_d  = 1'b1;
        cnt_d = cw'(1);
      end
      DRAIN: begin
        // l0_rd must stay high for the whole wave
        if (cnt_q == drain_n) begin
          nxt = DONE;
        end else begin
          rd_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        nxt   = IDLE;
        cnt_d = '0;
      end
      default: nxt = IDLE;
    endcase
    if (nxt == LOAD || nxt == FLUSH || nxt == DRAIN)
      busy_d = 1'b1;
    done_d = (nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      addr_q <= '0;
      cen_q  <= 1'b1;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      cen_q  <= cen_d;
      wr_q   <= ~cen_q;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.sram_cen  = cen_q;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = addr_q;
  assign bus.l0_wr     = wr_q;
  assign bus.l0_rd     = rd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
